lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store unit that initiates every data-memory transaction for the MIPS datapath. It accepts one load/store request from the execute stage and runs a small FSM against the word-wide data memory port: we, address, write_data, combinational read_data. Sub-word stores (SB/SH) are done by read-modify-write, because the memory has a single whole-word write enable. Loads return sign- or zero-extended data with a one-cycle done pulse; busy stalls the pipeline.

Parameters:
ADDR_W, 6, word-index width driven on mem_address; upper mem_address bits forced to 0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  request strobe; sampled only while busy=0
op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
addr  input  32  byte address
wdata  input  32  store data; SB uses [7:0], SH uses [15:0]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  misalignment flag; valid only with done
rdata  output  32  extended load result; held until next load completes
mem_we  output  1  memory write enable
mem_address  output  32  word index = addr[ADDR_W+1:2], zero-extended
mem_write_data  output  32  word to write
mem_read_data  input  32  combinational memory read data for mem_address

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, mem_we = 0; rdata, mem_address, mem_write_data = 0; captured op/addr/wdata cleared.
- Reset mid-operation aborts the access immediately: mem_we drops with no partial write, and no done is issued.
- States: IDLE, RD, WR, DONE.
- IDLE: if req=1, register op, addr and wdata. Next state by op:
  - loads and SH/SB -> RD
  - SW -> WR
  - misaligned access (when the check is enabled) -> DONE with err
- req while busy=1 is ignored; the requester holds req until busy=0.
- RD: mem_address driven. At the clock edge, capture mem_read_data.
  - loads: RD -> DONE
  - SH/SB: RD -> WR
- WR: mem_we=1 for exactly one cycle.
  - SW writes wdata.
  - SB writes the captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH writes the captured word with half lane addr[1] replaced by wdata[15:0].
  - WR -> DONE.
- DONE: done=1 for one cycle, then -> IDLE. A new req is accepted in the following IDLE cycle.
- Lane order is little-endian: byte k occupies bits [8k+7:8k]; half h occupies [16h+15:16h].
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word as-is.
- rdata updates on entry to DONE for loads only. Stores leave rdata unchanged. An errored access sets rdata to 0.
- Latency counted from the accept edge to done:
  - loads: 2 cycles
  - SW: 2 cycles
  - SH/SB: 3 cycles
  - misaligned: 1 cycle
- mem_address and mem_write_data are 0 in IDLE and DONE. mem_we is 0 outside WR.

Optional Feature:
LSU_ALIGN_CHECK_EN:
- Defined: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0, go IDLE->DONE with done=1, err=1 and rdata=0. No memory access and no mem_we.
- Undefined: err is tied to 0. Low address bits are ignored for word access (word at addr[ADDR_W+1:2]) and addr[0] is ignored for half access. All requests take the normal paths.

Test Plan:
- Preload word 3 = 0x8081F0F1. LB addr 0x0D -> rdata 0xFFFFFFF0, done 2 cycles after accept. LBU 0x0F -> 0x00000080.
- Same preload. LH 0x0E -> 0xFFFF8081. LHU 0x0C -> 0x0000F0F1. mem_we stays 0 throughout.
- SB 0x0D wdata 0x000000AA -> single mem_we pulse at mem_address 3; word 3 becomes 0x8081AAF1. Then SH 0x0E wdata 0x00001234 -> word 3 = 0x1234AAF1. Done 3 cycles after accept; rdata unchanged.
- SW 0x10 wdata 0xDEADBEEF -> mem_we high exactly one cycle with mem_address 4 and mem_write_data 0xDEADBEEF; done 2 cycles after accept. A req pulsed while busy is ignored.
- LW 0x0D with LSU_ALIGN_CHECK_EN -> done=1, err=1 one cycle after accept, rdata=0, no mem_we. Without the macro -> rdata 0x8081F0F1, err=0.
- SH 0x0C accepted, then rst_n=0 during RD -> no mem_we, all outputs 0, word 3 unchanged. After release, an LW 0x0C completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a word-wide data memory; sub-word stores use read-modify-write.
// Optional misalignment trap enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        misalign;
  logic [31:0] word_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] rmw_word;
  logic        unused_addr_bits;

  assign word_idx         = {{(32-ADDR_W){1'b0}}, addr[ADDR_W+1:2]};
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  always_comb begin
    misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    case (op)
      OP_LW, OP_SW:          misalign = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misalign = addr[0];
      default:               misalign = 1'b0;
    endcase
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from the word being read.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_read_data[7:0];
      2'd1:    byte_sel = mem_read_data[15:8];
      2'd2:    byte_sel = mem_read_data[23:16];
      default: byte_sel = mem_read_data[31:24];
    endcase
    half_sel = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    case (op_q)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = mem_read_data;
    endcase

    rmw_word = mem_read_data;
    if (op_q == OP_SH) begin
      if (lane_q[1]) rmw_word[31:16] = wdata_q;
      else           rmw_word[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    rmw_word[7:0]   = wdata_q[7:0];
        2'd1:    rmw_word[15:8]  = wdata_q[7:0];
        2'd2:    rmw_word[23:16] = wdata_q[7:0];
        default: rmw_word[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= 3'b000;
      lane_q         <= 2'b00;
      wdata_q        <= 16'h0000;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= 32'h0;
      mem_we         <= 1'b0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= op;
            lane_q  <= addr[1:0];
            wdata_q <= wdata[15:0];
            busy    <= 1'b1;
            if (misalign) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= 32'h0;
            end else if (op == OP_SW) begin
              state          <= WR;
              mem_we         <= 1'b1;
              mem_address    <= word_idx;
              mem_write_data <= wdata;
            end else begin
              state       <= RD;
              mem_address <= word_idx;
            end
          end
        end
        RD: begin
          if (op_q == OP_SH || op_q == OP_SB) begin
            state          <= WR;
            mem_we         <= 1'b1;
            mem_write_data <= rmw_word;
          end else begin
            state       <= DONE;
            done        <= 1'b1;
            err         <= 1'b0;
            rdata       <= load_val;
            mem_address <= 32'h0;
          end
        end
        WR: begin
          state          <= DONE;
          done           <= 1'b1;
          err            <= 1'b0;
          mem_address    <= 32'h0;
          mem_write_data <= 32'h0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, corner sequences and a random
// stream checked against a byte/half arithmetic reference model.
module tb_lsu_mem_ctrl;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

`ifdef LSU_ALIGN_CHECK_EN
  localparam logic [31:0] HELD = 32'h0;
`else
  localparam logic [31:0] HELD = 32'h8081F0F1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [64];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  logic [31:0] ref_mem [64];
  logic [31:0] ref_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          widx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [9];

  lsu_mem_ctrl #(.ADDR_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .op            (op),
    .addr          (addr),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .mem_we        (mem_we),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[5:0]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_address[5:0]] <= mem_write_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: byte/half arithmetic on a plain word array, updates model state.
  task automatic modelAccess(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] e_rdata, output logic e_err, output int e_lat,
                             output int e_we, output int e_idx, output logic [31:0] e_word);
    int idx, bo, ho;
    logic [31:0] w, b, h;
    bit mis;
    idx = int'((a / 4) % 64);
    bo  = int'(a % 4);
    ho  = int'((a / 2) % 2);
    w   = ref_mem[idx];
    mis = 0;
`ifdef LSU_ALIGN_CHECK_EN
    if ((o == OP_LW || o == OP_SW) && bo != 0) mis = 1;
    if ((o == OP_LH || o == OP_LHU || o == OP_SH) && (bo % 2) != 0) mis = 1;
`endif
    e_err = 1'b0;
    e_we  = 0;
    e_lat = 2;
    e_idx = idx;
    if (mis) begin
      e_err     = 1'b1;
      e_lat     = 1;
      ref_rdata = 32'h0;
    end else begin
      case (o)
        OP_LW: ref_rdata = w;
        OP_LH, OP_LHU: begin
          h = (w >> (16 * ho)) & 32'hFFFF;
          ref_rdata = (o == OP_LH && h >= 32'h8000) ? h + 32'hFFFF0000 : h;
        end
        OP_LB, OP_LBU: begin
          b = (w >> (8 * bo)) & 32'hFF;
          ref_rdata = (o == OP_LB && b >= 32'd128) ? b + 32'hFFFFFF00 : b;
        end
        OP_SW: begin
          e_we = 1;
          ref_mem[idx] = d;
        end
        OP_SH: begin
          e_we = 1;
          e_lat = 3;
          ref_mem[idx] = (w & ~(32'hFFFF << (16 * ho))) | ((d & 32'hFFFF) << (16 * ho));
        end
        default: begin
          e_we = 1;
          e_lat = 3;
          ref_mem[idx] = (w & ~(32'hFF << (8 * bo))) | ((d & 32'hFF) << (8 * bo));
        end
      endcase
    end
    e_rdata = ref_rdata;
    e_word  = ref_mem[idx];
  endtask

  // Issues one request, observes the transaction on falling edges; optional req noise while busy.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                               input bit noise, output logic [31:0] g_rdata, output logic g_err,
                               output int g_lat, output int g_we, output logic [31:0] g_we_addr,
                               output logic [31:0] g_we_data);
    int wait_cyc = 0;
    g_rdata = 0; g_err = 0; g_lat = 0; g_we = 0; g_we_addr = 0; g_we_data = 0;
    @(negedge clk);
    while (busy && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait busy=%b required=0", busy);
    end
    req = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (noise) begin
          op = OP_SW; addr = 32'h24; wdata = 32'h55667788;
        end else begin
          req = 1'b0;
        end
      end
      if (c == 2) req = 1'b0;
      if (mem_we) begin
        g_we++;
        g_we_addr = mem_address;
        g_we_data = mem_write_data;
      end
      if (done) begin
        g_lat   = c;
        g_rdata = rdata;
        g_err   = err;
        checkOutput("done_busy", busy, 1);
        checkOutput("done_mem_address", mem_address, 0);
        checkOutput("done_mem_wdata", mem_write_data, 0);
        break;
      end
    end
    req = 1'b0;
    if (g_lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout op=%0d addr=%h", o, a);
    end else begin
      @(negedge clk);
      checkOutput("done_pulse", done, 0);
      checkOutput("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [31:0] g_rdata, e_rdata, e_word, v;
    logic        g_err, e_err;
    int          g_lat, g_we, e_lat, e_we, e_idx;
    logic [31:0] g_we_addr, g_we_data;
    logic [2:0]  r_op;
    logic [31:0] r_addr, r_wdata;

    rst_n = 1'b0; req = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 6'd0; pre_val = 32'h0; ref_rdata = 32'h0;

    vecs[0] = '{OP_LB,  32'h0D, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 0, 3, 32'h8081F0F1};
    vecs[1] = '{OP_LBU, 32'h0F, 32'h0, 32'h00000080, 1'b0, 2, 0, 3, 32'h8081F0F1};
    vecs[2] = '{OP_LH,  32'h0E, 32'h0, 32'hFFFF8081, 1'b0, 2, 0, 3, 32'h8081F0F1};
    vecs[3] = '{OP_LHU, 32'h0C, 32'h0, 32'h0000F0F1, 1'b0, 2, 0, 3, 32'h8081F0F1};
`ifdef LSU_ALIGN_CHECK_EN
    vecs[4] = '{OP_LW,  32'h0D, 32'h0, 32'h00000000, 1'b1, 1, 0, 3, 32'h8081F0F1};
`else
    vecs[4] = '{OP_LW,  32'h0D, 32'h0, 32'h8081F0F1, 1'b0, 2, 0, 3, 32'h8081F0F1};
`endif
    vecs[5] = '{OP_SB,  32'h0D, 32'h000000AA, HELD, 1'b0, 3, 1, 3, 32'h8081AAF1};
    vecs[6] = '{OP_SH,  32'h0E, 32'h00001234, HELD, 1'b0, 3, 1, 3, 32'h1234AAF1};
    vecs[7] = '{OP_SW,  32'h10, 32'hDEADBEEF, HELD, 1'b0, 2, 1, 4, 32'hDEADBEEF};
    vecs[8] = '{OP_LB,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 4, 32'hDEADBEEF};

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = (i == 3) ? 32'h8081F0F1 : $urandom;
      pre_en = 1'b1; pre_idx = 6'(i); pre_val = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    pre_en = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_mem_wdata", mem_write_data, 0);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0,
                    g_rdata, g_err, g_lat, g_we, g_we_addr, g_we_data);
      checkOutput($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), g_err, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_latency", i), g_lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d_we_count", i), g_we, vecs[i].exp_we);
      if (vecs[i].exp_we != 0) begin
        checkOutput($sformatf("vec%0d_we_addr", i), g_we_addr, vecs[i].widx);
        checkOutput($sformatf("vec%0d_we_data", i), g_we_data, vecs[i].exp_word);
      end
      checkOutput($sformatf("vec%0d_mem_word", i), mem[vecs[i].widx], vecs[i].exp_word);
      modelAccess(vecs[i].op, vecs[i].addr, vecs[i].wdata, e_rdata, e_err, e_lat, e_we, e_idx, e_word);
    end

    $display("[TB] req while busy is ignored");
    modelAccess(OP_SW, 32'h20, 32'h11223344, e_rdata, e_err, e_lat, e_we, e_idx, e_word);
    applyStimulus(OP_SW, 32'h20, 32'h11223344, 1'b1, g_rdata, g_err, g_lat, g_we, g_we_addr, g_we_data);
    checkOutput("busyreq_latency", g_lat, 2);
    checkOutput("busyreq_we_count", g_we, 1);
    checkOutput("busyreq_word8", mem[8], 32'h11223344);
    checkOutput("busyreq_word9", mem[9], ref_mem[9]);

    $display("[TB] reset during read phase of a half store");
    @(negedge clk);
    req = 1'b1; op = OP_SH; addr = 32'h0C; wdata = 32'h0000BEEF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checkOutput("rd_busy", busy, 1);
    checkOutput("rd_mem_address", mem_address, 3);
    checkOutput("rd_mem_we", mem_we, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_mem_we", mem_we, 0);
    checkOutput("abort_rdata", rdata, 0);
    checkOutput("abort_mem_address", mem_address, 0);
    checkOutput("abort_mem_wdata", mem_write_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = 32'h0;
    checkOutput("abort_word3", mem[3], ref_mem[3]);
    modelAccess(OP_LW, 32'h0C, 32'h0, e_rdata, e_err, e_lat, e_we, e_idx, e_word);
    applyStimulus(OP_LW, 32'h0C, 32'h0, 1'b0, g_rdata, g_err, g_lat, g_we, g_we_addr, g_we_data);
    checkOutput("post_reset_lw_rdata", g_rdata, e_rdata);
    checkOutput("post_reset_lw_latency", g_lat, e_lat);

    $display("[TB] random stream against reference model");
    for (int n = 0; n < 300; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_wdata = $urandom;
      modelAccess(r_op, r_addr, r_wdata, e_rdata, e_err, e_lat, e_we, e_idx, e_word);
      applyStimulus(r_op, r_addr, r_wdata, 1'b0, g_rdata, g_err, g_lat, g_we, g_we_addr, g_we_data);
      checkOutput("rand_rdata", g_rdata, e_rdata);
      checkOutput("rand_err", g_err, e_err);
      checkOutput("rand_latency", g_lat, e_lat);
      checkOutput("rand_we_count", g_we, e_we);
      if (e_we != 0) begin
        checkOutput("rand_we_addr", g_we_addr, e_idx);
        checkOutput("rand_we_data", g_we_data, e_word);
      end
      checkOutput("rand_mem_word", mem[e_idx], e_word);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
